// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, computes ALU/divide result, issues data SRAM requests.
// Latency: 1 cycle for ALU/memory ops, 34 cycles from latch to es_ready_go for div/mod.
// Backpressure: holds instruction (and any finished divide result) while ms_allowin=0.

module alu (
   input  logic [11:0] alu_op,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);
   // one-hot op select: add sub slt sltu and nor or xor sll srl sra lui
   logic [31:0] add_res, sub_res, slt_res, sltu_res, sra_res;

   assign add_res  = alu_src1 + alu_src2;
   assign sub_res  = alu_src1 - alu_src2;
   assign slt_res  = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
   assign sltu_res = {31'd0, alu_src1 < alu_src2};
   assign sra_res  = $signed(alu_src1) >>> alu_src2[4:0];

   assign alu_result = ({32{alu_op[0]}}  & add_res)
                     | ({32{alu_op[1]}}  & sub_res)
                     | ({32{alu_op[2]}}  & slt_res)
                     | ({32{alu_op[3]}}  & sltu_res)
                     | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                     | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                     | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                     | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                     | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
                     | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
                     | ({32{alu_op[10]}} & sra_res)
                     | ({32{alu_op[11]}} & alu_src2);
endmodule

module exe_stage (
   input  logic         clk,
   input  logic         reset,
   input  logic         ms_allowin,
   output logic         es_allowin,
   input  logic         ds_to_es_valid,
   input  logic [150:0] ds_to_es_bus,
   output logic         es_to_ms_valid,
   output logic [70:0]  es_to_ms_bus,
   output logic         data_sram_en,
   output logic [3:0]   data_sram_wen,
   output logic [31:0]  data_sram_addr,
   output logic [31:0]  data_sram_wdata,
   output logic [38:0]  es_fwd_blk_bus
);
   typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

   logic         es_valid;
   logic [150:0] es_bus;
   logic [2:0]   div_op;
   logic [11:0]  alu_op;
   logic         mem_we, res_from_mem, gr_we;
   logic [4:0]   dest;
   logic [31:0]  store_data, alu_src1, alu_src2, pc;
   logic [31:0]  alu_result, es_result;
   logic         es_ready_go, es_leave, mem_req, es_fwd_valid, es_blk;

   div_state_t   div_state, div_state_nxt;
   logic         div_done, div_start;
   logic [31:0]  div_rem, div_quo, div_dsr, div_result;
   logic [4:0]   div_cnt;
   logic         div_neg_q, div_neg_r;
   logic [32:0]  div_trial;
   logic         div_ge;
   logic [31:0]  div_rem_nxt, div_quo_nxt, div_q_fin, div_r_fin;
   logic [31:0]  abs_src1, abs_src2;

   assign {div_op, alu_op, mem_we, res_from_mem, gr_we, dest,
           store_data, alu_src1, alu_src2, pc} = es_bus;

   alu u_alu (
      .alu_op     (alu_op),
      .alu_src1   (alu_src1),
      .alu_src2   (alu_src2),
      .alu_result (alu_result)
   );

   assign es_ready_go    = div_op[2] ? div_done : 1'b1;
   assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
   assign es_to_ms_valid = es_valid && es_ready_go;
   assign es_leave       = es_to_ms_valid && ms_allowin;

   // valid flag follows decode whenever the stage can accept
   always_ff @(posedge clk) begin
      if (reset)           es_valid <= 1'b0;
      else if (es_allowin) es_valid <= ds_to_es_valid;
   end

   // payload captured only on an actual handoff
   always_ff @(posedge clk) begin
      if (reset)                             es_bus <= '0;
      else if (ds_to_es_valid && es_allowin) es_bus <= ds_to_es_bus;
   end

   // one restoring step: shift next dividend bit into the partial remainder
   assign div_trial   = {div_rem, div_quo[31]};
   assign div_ge      = div_trial >= {1'b0, div_dsr};
   assign div_rem_nxt = div_ge ? 32'(div_trial - {1'b0, div_dsr}) : div_trial[31:0];
   assign div_quo_nxt = {div_quo[30:0], div_ge};
   assign div_q_fin   = div_neg_q ? -div_quo_nxt : div_quo_nxt;
   assign div_r_fin   = div_neg_r ? -div_rem_nxt : div_rem_nxt;
   assign abs_src1    = (div_op[1] && alu_src1[31]) ? -alu_src1 : alu_src1;
   assign abs_src2    = (div_op[1] && alu_src2[31]) ? -alu_src2 : alu_src2;
   assign div_start   = es_valid && div_op[2] && !div_done;

   // divider state register
   always_ff @(posedge clk) begin
      if (reset) div_state <= DIV_IDLE;
      else       div_state <= div_state_nxt;
   end

   // divider sequencing: start on a fresh divide, 32 steps, hold until the instruction leaves
   always_comb begin
      div_state_nxt = div_state;
      case (div_state)
         DIV_IDLE: if (div_start)       div_state_nxt = DIV_RUN;
         DIV_RUN:  if (div_cnt == 5'd31) div_state_nxt = DIV_DONE;
         DIV_DONE: if (es_leave)        div_state_nxt = DIV_IDLE;
         default:                       div_state_nxt = DIV_IDLE;
      endcase
   end

   // divider datapath; zero divisor never negates the all-ones quotient
   always_ff @(posedge clk) begin
      if (reset) begin
         div_rem    <= '0;
         div_quo    <= '0;
         div_dsr    <= '0;
         div_cnt    <= '0;
         div_neg_q  <= 1'b0;
         div_neg_r  <= 1'b0;
         div_result <= '0;
         div_done   <= 1'b0;
      end else begin
         div_done <= (div_state_nxt == DIV_DONE);
         if (div_state == DIV_IDLE && div_start) begin
            div_rem   <= '0;
            div_quo   <= abs_src1;
            div_dsr   <= abs_src2;
            div_cnt   <= '0;
            div_neg_q <= div_op[1] && (alu_src1[31] ^ alu_src2[31]) && (alu_src2 != 32'd0);
            div_neg_r <= div_op[1] && alu_src1[31];
         end else if (div_state == DIV_RUN) begin
            div_rem <= div_rem_nxt;
            div_quo <= div_quo_nxt;
            div_cnt <= div_cnt + 5'd1;
            if (div_cnt == 5'd31) div_result <= div_op[0] ? div_r_fin : div_q_fin;
         end
      end
   end

   assign es_result    = div_op[2] ? div_result : alu_result;
   assign es_to_ms_bus = {res_from_mem, gr_we, dest, es_result, pc};

   // memory request only in the handoff cycle, so each memory op fires once
   assign mem_req         = es_valid && ms_allowin && (mem_we || res_from_mem);
   assign data_sram_en    = mem_req;
   assign data_sram_wen   = (mem_req && mem_we) ? 4'hF : 4'h0;
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = store_data;

   assign es_fwd_valid   = es_valid && gr_we;
   assign es_blk         = es_fwd_valid && (res_from_mem || (div_op[2] && !div_done));
   assign es_fwd_blk_bus = {es_blk, es_fwd_valid, dest, es_result};
endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
   logic         clk = 1'b0;
   logic         reset;
   logic         ms_allowin;
   logic         es_allowin;
   logic         ds_to_es_valid;
   logic [150:0] ds_to_es_bus;
   logic         es_to_ms_valid;
   logic [70:0]  es_to_ms_bus;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
   logic [38:0]  es_fwd_blk_bus;

   exe_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ms_allowin      (ms_allowin),
      .es_allowin      (es_allowin),
      .ds_to_es_valid  (ds_to_es_valid),
      .ds_to_es_bus    (ds_to_es_bus),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .es_fwd_blk_bus  (es_fwd_blk_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [150:0] bus;
      logic [70:0]  exp_bus;
      bit           is_div;
      bit           mem;
      bit           mem_we;
      bit           rfm;
      bit           gr_we;
      logic [4:0]   dest;
      logic [31:0]  result;
      logic [31:0]  addr;
      logic [31:0]  wdata;
      int           lat;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   passed = 0;
   int   ncyc = 0;
   bit   mon_en = 0;
   bit   rand_ms = 0;

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
   endfunction

   // reference ALU: op index selects one operation
   function automatic logic [31:0] ref_alu(int sel, logic [31:0] a, logic [31:0] b);
      logic [31:0] r;
      case (sel)
         0: r = a + b;
         1: r = a - b;
         2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3: r = (a < b) ? 32'd1 : 32'd0;
         4: r = a & b;
         5: r = ~(a | b);
         6: r = a | b;
         7: r = a ^ b;
         8: r = a << b[4:0];
         9: r = a >> b[4:0];
         10: r = $signed(a) >>> b[4:0];
         default: r = b;
      endcase
      return r;
   endfunction

   // reference divider from the arithmetic definition
   function automatic logic [31:0] ref_div(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      logic [31:0] qv, rv;
      if (b == 0) begin
         qv = 32'hFFFF_FFFF; rv = a;
      end else if (op[1]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            qv = 32'h8000_0000; rv = 0;
         end else begin
            qv = $signed(a) / $signed(b);
            rv = $signed(a) % $signed(b);
         end
      end else begin
         qv = a / b; rv = a % b;
      end
      return op[0] ? rv : qv;
   endfunction

   function automatic exp_t mk(logic [2:0] dop, int sel, bit mwe, bit rfm, bit gwe, logic [4:0] dst,
                               logic [31:0] sd, logic [31:0] s1, logic [31:0] s2, logic [31:0] pc);
      exp_t e;
      logic [11:0] aop;
      aop      = 12'd1 << sel;
      e.bus    = {dop, aop, mwe, rfm, gwe, dst, sd, s1, s2, pc};
      e.is_div = dop[2];
      e.mem    = mwe || rfm;
      e.mem_we = mwe;
      e.rfm    = rfm;
      e.gr_we  = gwe;
      e.dest   = dst;
      e.addr   = ref_alu(sel, s1, s2);
      e.wdata  = sd;
      e.result = dop[2] ? ref_div(dop, s1, s2) : e.addr;
      e.exp_bus = {rfm, gwe, dst, e.result, pc};
      e.lat    = 0;
      return e;
   endfunction

   function automatic exp_t rand_instr();
      int kind, sel;
      logic [31:0] s1, s2;
      logic [2:0] dop;
      kind = $urandom_range(0, 9);
      s1 = $urandom; s2 = $urandom;
      if (kind <= 4) begin
         sel = $urandom_range(0, 11);
         return mk(3'b000, sel, 0, 0, 1'($urandom), 5'($urandom), $urandom, s1, s2, $urandom);
      end else if (kind == 5) begin
         return mk(3'b000, 0, 0, 1, 1, 5'($urandom), $urandom, s1, s2, $urandom);
      end else if (kind == 6) begin
         return mk(3'b000, 0, 1, 0, 0, 5'($urandom), $urandom, s1, s2, $urandom);
      end
      dop = {1'b1, 2'($urandom)};
      case ($urandom_range(0, 4))
         0: s2 = 0;
         1: begin s1 = 32'h8000_0000; s2 = 32'hFFFF_FFFF; end
         2: s2 = $urandom_range(1, 17);
         3: s2 = -$urandom_range(1, 17);
         default: ;
      endcase
      return mk(dop, $urandom_range(0, 11), 0, 0, 1'($urandom), 5'($urandom), $urandom, s1, s2, $urandom);
   endfunction

   // driver: hold the offer until the stage accepts it, push expectation at the accepting edge
   task automatic issue(input exp_t e);
      bit acc = 0;
      int n = 0;
      ds_to_es_bus   = e.bus;
      ds_to_es_valid = 1'b1;
      while (!acc && n < 300) begin
         @(negedge clk);
         acc = es_allowin && !reset;
         @(posedge clk);
         if (acc) begin
            e.lat = ncyc;
            q.push_back(e);
         end
         #1;
         n++;
      end
      ds_to_es_valid = 1'b0;
      if (!acc) chk("issue_timeout", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   always @(posedge clk) begin
      if (rand_ms) begin
         #1;
         ms_allowin = ($urandom_range(0, 3) != 0);
      end
   end

   // monitor: compares DUT outputs against the occupant of the scoreboard every cycle
   exp_t e;
   bit   occ, rg, exp_v, leave, exp_en, exp_fv, exp_blk;
   int   k;
   always @(negedge clk) begin
      ncyc++;
      if (mon_en && !reset) begin
         occ = (q.size() != 0);
         rg = 0;
         if (occ) begin
            e  = q[0];
            k  = ncyc - e.lat;
            rg = (k >= (e.is_div ? 34 : 1));
         end
         exp_v  = occ && rg;
         leave  = exp_v && ms_allowin;
         exp_en = leave && e.mem;
         chk("es_to_ms_valid", es_to_ms_valid, exp_v);
         chk("es_allowin", es_allowin, !occ || (rg && ms_allowin));
         chk("sram_en", data_sram_en, exp_en);
         if (exp_en) begin
            chk("sram_wen", data_sram_wen, e.mem_we ? 4'hF : 4'h0);
            chk("sram_addr", data_sram_addr, e.addr);
            if (e.mem_we) chk("sram_wdata", data_sram_wdata, e.wdata);
         end
         if (exp_v) chk("es_to_ms_bus", es_to_ms_bus, e.exp_bus);
         exp_fv  = occ && e.gr_we;
         exp_blk = exp_fv && (e.rfm || (e.is_div && !rg));
         chk("fwd_blk_valid", es_fwd_blk_bus[38:37], {exp_blk, exp_fv});
         if (occ) chk("fwd_dest", es_fwd_blk_bus[36:32], e.dest);
         if (exp_fv && !exp_blk) chk("fwd_data", es_fwd_blk_bus[31:0], e.result);
         if (leave) void'(q.pop_front());
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ms_allowin = 1'b0; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_allowin", es_allowin, 1);
      chk("rst_to_ms_valid", es_to_ms_valid, 0);
      chk("rst_to_ms_bus", es_to_ms_bus, 0);
      chk("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 0);
      chk("rst_fwd", es_fwd_blk_bus, 0);
      mon_en = 1;

      // add 5+7 into r3
      ms_allowin = 1;
      issue(mk(3'b000, 0, 0, 0, 1, 5'd3, 0, 5, 7, 32'h1c00_0000));
      drain();
      // load stalled two cycles
      ms_allowin = 0;
      issue(mk(3'b000, 0, 0, 1, 1, 5'd4, 0, 32'h1000, 0, 32'h1c00_0004));
      repeat (2) begin @(posedge clk); #1; end
      ms_allowin = 1;
      drain();
      // store
      issue(mk(3'b000, 0, 1, 0, 0, 5'd0, 32'hDEAD_BEEF, 32'h2000, 4, 32'h1c00_0008));
      drain();
      // directed divides
      issue(mk(3'b100, 0, 0, 0, 1, 5'd5, 0, 100, 7, 32'h10)); drain();
      issue(mk(3'b101, 0, 0, 0, 1, 5'd5, 0, 100, 7, 32'h14)); drain();
      issue(mk(3'b111, 0, 0, 0, 1, 5'd6, 0, -7, 2, 32'h18)); drain();
      issue(mk(3'b110, 0, 0, 0, 1, 5'd6, 0, -7, 2, 32'h1c)); drain();
      issue(mk(3'b100, 0, 0, 0, 1, 5'd7, 0, 9, 0, 32'h20)); drain();
      issue(mk(3'b110, 0, 0, 0, 1, 5'd7, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h24)); drain();
      // divide finishes while memory stage stalls
      ms_allowin = 0;
      issue(mk(3'b100, 0, 0, 0, 1, 5'd8, 0, 1000, 3, 32'h28));
      repeat (38) begin @(posedge clk); #1; end
      ms_allowin = 1;
      drain();
      // back-to-back divides: second enters as the first leaves
      issue(mk(3'b110, 0, 0, 0, 1, 5'd9, 0, 12345, -11, 32'h2c));
      issue(mk(3'b101, 0, 0, 0, 1, 5'd10, 0, 999, 10, 32'h30));
      drain();
      // reset in the middle of a divide
      issue(mk(3'b100, 0, 0, 0, 1, 5'd11, 0, 77, 5, 32'h34));
      repeat (10) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk);
      q.delete();
      #1 reset = 1'b0;
      chk("midrst_allowin", es_allowin, 1);
      chk("midrst_to_ms_valid", es_to_ms_valid, 0);
      chk("midrst_sram_en", data_sram_en, 0);
      issue(mk(3'b100, 0, 0, 0, 1, 5'd12, 0, 100, 7, 32'h38));
      drain();

      // randomized traffic with random downstream stalls
      rand_ms = 1;
      repeat (150) begin
         issue(rand_instr());
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      rand_ms = 0;
      @(posedge clk); #2;
      ms_allowin = 1;
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order pipeline, between the decode stage (upstream) and the memory stage (downstream).
- Latches the decode-to-execute bus and computes the ALU result through the existing alu module.
- Runs a multi-cycle iterative divider for div/mod instructions.
- Issues data SRAM requests, whose read data the memory stage consumes on the following cycle.
- Exports a forward/block bus so decode can bypass or stall.

Parameters:
none (all widths fixed by the bus layouts below)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ms_allowin  in  1  memory stage can accept
es_allowin  out  1  execute stage can accept
ds_to_es_valid  in  1  decode offers an instruction
ds_to_es_bus  in  151  {div_op[3] 150:148, alu_op[12] 147:136, mem_we 135, res_from_mem 134, gr_we 133, dest[5] 132:128, store_data[32] 127:96, alu_src1[32] 95:64, alu_src2[32] 63:32, pc[32] 31:0}
es_to_ms_valid  out  1  instruction ready for memory stage
es_to_ms_bus  out  71  {res_from_mem 70, gr_we 69, dest 68:64, result 63:32, pc 31:0}
data_sram_en  out  1  data SRAM enable
data_sram_wen  out  4  byte write enables
data_sram_addr  out  32  byte address
data_sram_wdata  out  32  write data
es_fwd_blk_bus  out  39  {es_blk 38, es_fwd_valid 37, dest 36:32, data 31:0}

Behaviour:
- Reset values:
  - es_valid=0, divider IDLE, div_done=0.
  - All outputs are 0 except es_allowin=1.
- Handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - On a clock edge with es_allowin=1: es_valid <= ds_to_es_valid.
  - The bus is latched only when ds_to_es_valid && es_allowin.
  - es_to_ms_valid = es_valid && es_ready_go.
- es_ready_go:
  - Equals 1 for non-divide instructions.
  - For divide instructions (div_op[2]=1) it equals div_done.
- div_op encoding: [2]=divide, [1]=signed, [0]=return remainder (else quotient).
- Divider FSM: IDLE -> RUN -> DONE.
  - IDLE: when es_valid && div_op[2] && !div_done, load |src1|, |src2| (absolute values only when signed) and count=0, then go to RUN.
  - RUN: restoring division, one quotient bit per cycle for 32 cycles (count 0..31).
  - DONE: after the 32nd iteration apply signs (quotient negated if sign1^sign2, remainder takes sign1), register the result, set div_done=1.
  - Latency: instruction latched at edge T0 → IDLE in cycle 1, RUN cycles 2..33, es_ready_go=1 from cycle 34.
  - div_done and the result are held while ms_allowin=0; the divider must not restart.
  - div_done clears when the instruction leaves ES (es_to_ms_valid && ms_allowin).
- Divide by zero:
  - Quotient = 0xFFFFFFFF, remainder = src1, for both signed and unsigned.
  - Still takes full latency.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- result field = divider result if div_op[2], else alu_result.
- Data SRAM:
  - mem_req = es_valid && ms_allowin && (mem_we || res_from_mem).
  - data_sram_en = mem_req.
  - data_sram_wen = (mem_req && mem_we) ? 4'hF : 4'h0.
  - data_sram_addr = alu_result; data_sram_wdata = store_data.
  - Word accesses only.
  - A request is issued only in the cycle the instruction moves to MS, so exactly one request per memory instruction.
- Forwarding:
  - es_fwd_valid = es_valid && gr_we.
  - es_blk = es_fwd_valid && (res_from_mem || (div_op[2] && !div_done)).
  - data = the result field.
- Reset mid-divide: divider returns to IDLE, es_valid=0, no SRAM request issued, in the same edge.
- Simultaneous leave and enter: a new instruction latched on the same edge the previous one leaves starts its divide from IDLE; there is no stale div_done.

Test Plan:
- ALU add, src1=5, src2=7, gr_we=1, dest=3, ms_allowin=1 → next cycle es_to_ms_valid=1, result=12, es_fwd_blk_bus={0,1,3,12}.
- Load, alu_result=0x1000, ms_allowin=0 for 2 cycles then 1 → data_sram_en=0 while stalled, then en=1, addr=0x1000, wen=0 for exactly one cycle; es_blk=1 throughout.
- Store, addr 0x2004, store_data=0xDEADBEEF → one cycle with en=1, wen=4'hF, wdata=0xDEADBEEF.
- Unsigned div 100/7 → es_ready_go=1 in cycle 34 after latch, result=14; the same operands with div_op[0]=1 give result=2; es_blk=1 until done.
- Signed -7 mod 2 → 0xFFFFFFFF; signed -7/2 → 0xFFFFFFFD; 9/0 unsigned → 0xFFFFFFFF; 0x80000000 / -1 signed → 0x80000000.
- Divide completes with ms_allowin=0 for 5 cycles → result stable, no restart, leaves on first ms_allowin=1.
- Reset asserted at RUN cycle 10 → es_valid=0, es_allowin=1, a following div completes with correct latency.
